// File: rtl/vga_timing_gen_if.sv
// Video timing bundle: run/pattern controls in, raster position, syncs and colour out.
// The generator drives the slave side. Whoever consumes the raster drives the master side.
interface vga_timing_gen_if #(
  parameter int CW    = 4,
  parameter int CNT_W = 11
) ();

  logic              en;
  logic [1:0]        pattern_sel;
  logic [3*CW-1:0]   rgb_in;

  logic              pix_stb;
  logic [CNT_W-1:0]  hcount;
  logic [CNT_W-1:0]  vcount;
  logic              line_start;
  logic              frame_start;
  logic              active;
  logic              hsync;
  logic              vsync;
  logic [CW-1:0]     red;
  logic [CW-1:0]     green;
  logic [CW-1:0]     blue;

  modport master (
    output en, pattern_sel, rgb_in,
    input  pix_stb, hcount, vcount, line_start, frame_start,
    input  active, hsync, vsync, red, green, blue
  );

  modport slave (
    input  en, pattern_sel, rgb_in,
    output pix_stb, hcount, vcount, line_start, frame_start,
    output active, hsync, vsync, red, green, blue
  );

endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with a built-in test-pattern source.
// The system clock is divided down to a pixel strobe. Free-running column and line counters
// are decoded into sync, visible-area and colour outputs. Those outputs are registered one
// pixel slot behind the counters.
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FP      = 40,
  parameter int H_SYNC    = 128,
  parameter int H_BP      = 88,
  parameter int V_VISIBLE = 600,
  parameter int V_FP      = 1,
  parameter int V_SYNC    = 4,
  parameter int V_BP      = 23,
  parameter int CLK_DIV   = 6,
  parameter int HSYNC_POL = 1,
  parameter int VSYNC_POL = 1,
  parameter int CW        = 4,
  parameter int CNT_W     = 11
) (
  input  logic               clk,
  input  logic               nrst,
  vga_timing_gen_if.slave    bus
);

  // Raster geometry, all resolved at elaboration.
  localparam int H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VISIBLE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VISIBLE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Colour bars are H_VISIBLE/8 pixels wide. The guard keeps tiny test rasters from dividing by zero.
  localparam int BAR_W    = (H_VISIBLE / 8 > 0) ? H_VISIBLE / 8 : 1;
  localparam int BAR_MAX  = (H_VISIBLE > 0) ? (H_VISIBLE - 1) / BAR_W : 0;

  localparam int TICK_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]  H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]  V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]  H_VIS_END = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0]  V_VIS_END = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0]  HS_LO     = CNT_W'(HS_START);
  localparam logic [CNT_W-1:0]  HS_HI     = CNT_W'(HS_END);
  localparam logic [CNT_W-1:0]  VS_LO     = CNT_W'(VS_START);
  localparam logic [CNT_W-1:0]  VS_HI     = CNT_W'(VS_END);

  // Line-number bit masks for the gradient.
  // If CNT_W is too small to hold a bit, its mask truncates to zero and the bit reads as 0.
  localparam logic [CNT_W-1:0]  V_BIT6    = CNT_W'(64);
  localparam logic [CNT_W-1:0]  V_BIT7    = CNT_W'(128);
  localparam logic [CNT_W-1:0]  V_BIT8    = CNT_W'(256);

  localparam logic HS_ON = (HSYNC_POL != 0);
  localparam logic VS_ON = (VSYNC_POL != 0);

  logic [TICK_W-1:0] r_tick;
  logic [CNT_W-1:0]  r_hcount;
  logic [CNT_W-1:0]  r_vcount;
  logic [1:0]        r_pattern;
  logic              r_active;
  logic              r_hsync;
  logic              r_vsync;
  logic [CW-1:0]     r_red;
  logic [CW-1:0]     r_green;
  logic [CW-1:0]     r_blue;

  logic              w_pix_stb;
  logic              w_h_last;
  logic              w_v_last;
  logic              w_line_start;
  logic              w_frame_start;
  logic              w_visible;
  logic              w_hs_on;
  logic              w_vs_on;
  logic [1:0]        w_pattern;
  logic [CW-1:0]     w_grad;
  logic [2:0]        w_bar;
  logic [CW-1:0]     w_pat_r;
  logic [CW-1:0]     w_pat_g;
  logic [CW-1:0]     w_pat_b;

  assign w_pix_stb     = bus.en && (r_tick == '0);
  assign w_h_last      = (r_hcount == H_LAST);
  assign w_v_last      = (r_vcount == V_LAST);
  assign w_line_start  = w_pix_stb && (r_hcount == '0);
  assign w_frame_start = w_line_start && (r_vcount == '0);

  assign w_visible = (r_hcount < H_VIS_END) && (r_vcount < V_VIS_END);
  assign w_hs_on   = (r_hcount >= HS_LO) && (r_hcount < HS_HI);
  assign w_vs_on   = (r_vcount >= VS_LO) && (r_vcount < VS_HI);

  // At frame_start, the pattern selected at that moment colours the very first pixel.
  assign w_pattern = w_frame_start ? bus.pattern_sel : r_pattern;
  assign w_grad    = r_hcount[CW+4:5];

  // Pixel-clock divider: tick cycles 0..CLK_DIV-1, and a strobe fires on tick 0.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_tick <= '0;
    end else if (!bus.en) begin
      r_tick <= '0;
    end else if (r_tick == TICK_LAST) begin
      r_tick <= '0;
    end else begin
      r_tick <= r_tick + TICK_W'(1);
    end
  end

  // Raster counters. The column wraps at the line end and carries into the line counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (!bus.en) begin
      r_hcount <= '0;
      r_vcount <= '0;
    end else if (w_pix_stb) begin
      if (w_h_last) begin
        r_hcount <= '0;
        if (w_v_last) begin
          r_vcount <= '0;
        end else begin
          r_vcount <= r_vcount + CNT_W'(1);
        end
      end else begin
        r_hcount <= r_hcount + CNT_W'(1);
      end
    end
  end

  // Pattern selection is latched once per frame, so a mid-frame change waits for the next frame.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pattern <= 2'd0;
    end else if (w_frame_start) begin
      r_pattern <= bus.pattern_sel;
    end
  end

  // Pattern source mux. Bar index is floor(h/BAR_W), built from constant thresholds; only its low 3 bits matter.
  always_comb begin
    w_bar   = 3'd0;
    w_pat_r = '0;
    w_pat_g = '0;
    w_pat_b = '0;
    for (int k = 1; k <= BAR_MAX; k++) begin
      if (r_hcount >= CNT_W'(k * BAR_W)) begin
        w_bar = 3'(k);
      end
    end
    case (w_pattern)
      2'd0: begin
        w_pat_r = bus.rgb_in[3*CW-1 -: CW];
        w_pat_g = bus.rgb_in[2*CW-1 -: CW];
        w_pat_b = bus.rgb_in[CW-1 -: CW];
      end
      2'd1: begin
        w_pat_r = w_grad & {CW{|(r_vcount & V_BIT8)}};
        w_pat_g = w_grad & {CW{|(r_vcount & V_BIT7)}};
        w_pat_b = w_grad & {CW{|(r_vcount & V_BIT6)}};
      end
      2'd2: begin
        w_pat_r = {CW{w_bar[2]}};
        w_pat_g = {CW{w_bar[1]}};
        w_pat_b = {CW{w_bar[0]}};
      end
      default: begin
        w_pat_r = {CW{r_hcount[4] ^ r_vcount[4]}};
        w_pat_g = {CW{r_hcount[4] ^ r_vcount[4]}};
        w_pat_b = {CW{r_hcount[4] ^ r_vcount[4]}};
      end
    endcase
  end

  // Registered video outputs. They follow the counters by one pixel slot and hold between strobes.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_active <= 1'b0;
      r_hsync  <= ~HS_ON;
      r_vsync  <= ~VS_ON;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
    end else if (!bus.en) begin
      r_active <= 1'b0;
      r_hsync  <= ~HS_ON;
      r_vsync  <= ~VS_ON;
      r_red    <= '0;
      r_green  <= '0;
      r_blue   <= '0;
    end else if (w_pix_stb) begin
      r_active <= w_visible;
      r_hsync  <= w_hs_on ? HS_ON : ~HS_ON;
      r_vsync  <= w_vs_on ? VS_ON : ~VS_ON;
      r_red    <= w_visible ? w_pat_r : '0;
      r_green  <= w_visible ? w_pat_g : '0;
      r_blue   <= w_visible ? w_pat_b : '0;
    end
  end

  assign bus.pix_stb     = w_pix_stb;
  assign bus.hcount      = r_hcount;
  assign bus.vcount      = r_vcount;
  assign bus.line_start  = w_line_start;
  assign bus.frame_start = w_frame_start;
  assign bus.active      = r_active;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.red         = r_red;
  assign bus.green       = r_green;
  assign bus.blue        = r_blue;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a reduced raster.
// The reference model derives raster position from the count of enabled cycles since the last
// clear, using plain division and modulo. It rebuilds the registered outputs from the raster rules.
module tb_vga_timing_gen;

  localparam int HV  = 40;
  localparam int HF  = 2;
  localparam int HS  = 4;
  localparam int HB  = 2;
  localparam int VV  = 264;
  localparam int VF  = 1;
  localparam int VS  = 2;
  localparam int VB  = 1;
  localparam int DIV = 2;
  localparam int HP  = 0;
  localparam int VP  = 1;
  localparam int CW  = 2;
  localparam int CNT_W = 9;
  localparam int HT  = HV + HF + HS + HB;
  localparam int VT  = VV + VF + VS + VB;
  localparam int MASK = (1 << CW) - 1;
  localparam int MISS_LIMIT = 20;

  logic clk = 1'b0;
  logic nrst;

  int vectorCount = 0;
  int missCount   = 0;

  // Reference model state
  int n;
  int eAct, eHs, eVs, eR, eG, eB, ePat;
  int rgbIn;

  vga_timing_gen_if #(.CW(CW), .CNT_W(CNT_W)) vif ();

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(DIV), .HSYNC_POL(HP), .VSYNC_POL(VP),
    .CW(CW), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (vif)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic modelClearOutputs();
    n    = 0;
    eAct = 0;
    eHs  = (HP != 0) ? 0 : 1;
    eVs  = (VP != 0) ? 0 : 1;
    eR   = 0;
    eG   = 0;
    eB   = 0;
  endtask

  task automatic modelReset();
    modelClearOutputs();
    ePat = 0;
  endtask

  // Strobes seen so far; hcount/vcount follow from it directly.
  function automatic int slotsDone();
    return (n + DIV - 1) / DIV;
  endfunction

  task automatic modelStep(input bit enV, input int psel);
    int pos, h, v, bar, g;
    bit vis;
    if (!enV) begin
      modelClearOutputs();
    end else begin
      if (n % DIV == 0) begin
        pos = slotsDone();
        h = pos % HT;
        v = (pos / HT) % VT;
        if (h == 0 && v == 0) ePat = psel;
        vis  = (h < HV) && (v < VV);
        eAct = vis ? 1 : 0;
        eHs  = (h >= HV + HF && h < HV + HF + HS) ? HP : 1 - HP;
        eVs  = (v >= VV + VF && v < VV + VF + VS) ? VP : 1 - VP;
        eR = 0; eG = 0; eB = 0;
        if (vis) begin
          case (ePat)
            0: begin
              eR = (rgbIn >> (2 * CW)) & MASK;
              eG = (rgbIn >> CW) & MASK;
              eB = rgbIn & MASK;
            end
            1: begin
              g  = (h >> 5) & MASK;
              eR = ((v >> 8) & 1) ? g : 0;
              eG = ((v >> 7) & 1) ? g : 0;
              eB = ((v >> 6) & 1) ? g : 0;
            end
            2: begin
              bar = h / (HV / 8);
              eR = ((bar >> 2) & 1) ? MASK : 0;
              eG = ((bar >> 1) & 1) ? MASK : 0;
              eB = (bar & 1) ? MASK : 0;
            end
            default: begin
              g  = (((h >> 4) ^ (v >> 4)) & 1) ? MASK : 0;
              eR = g; eG = g; eB = g;
            end
          endcase
        end
      end
      n++;
    end
  endtask

  task automatic compareAll(input bit enV);
    int pos, h, v, stb;
    pos = slotsDone();
    h   = pos % HT;
    v   = (pos / HT) % VT;
    stb = (enV && (n % DIV == 0)) ? 1 : 0;
    checkOutput("strobes", {29'd0, vif.pix_stb, vif.line_start, vif.frame_start},
                32'((stb << 2) | ((stb && h == 0) << 1) | (stb && h == 0 && v == 0)));
    checkOutput("hcount", 32'(vif.hcount), 32'(h));
    checkOutput("vcount", 32'(vif.vcount), 32'(v));
    checkOutput("active/hsync/vsync", {29'd0, vif.active, vif.hsync, vif.vsync},
                32'((eAct << 2) | (eHs << 1) | eVs));
    checkOutput("rgb", {26'd0, vif.red, vif.green, vif.blue},
                32'((eR << (2 * CW)) | (eG << CW) | eB));
  endtask

  // One clock of stimulus: drive inputs at the falling edge, check before the rising edge, then advance the model.
  task automatic applyStimulus(input bit nrstV, input bit enV, input int psel);
    @(negedge clk);
    nrst            = nrstV;
    vif.en          = enV;
    vif.pattern_sel = 2'(psel);
    rgbIn           = int'($urandom_range(0, (1 << (3 * CW)) - 1));
    vif.rgb_in      = (3 * CW)'(rgbIn);
    if (!nrstV) modelReset();
    #1;
    if (missCount < MISS_LIMIT) compareAll(enV);
    @(posedge clk);
    if (nrstV) modelStep(enV, psel);
  endtask

  initial begin
    int sel, other, drops, len, mid;
    bit found;
    nrst            = 1'b0;
    vif.en          = 1'b1;
    vif.pattern_sel = 2'd1;
    vif.rgb_in      = '0;
    rgbIn           = 0;
    modelReset();

    repeat (3) applyStimulus(1'b0, 1'b1, 1);

    // First frame in gradient mode. The mid-frame change only lands on the next frame.
    other = int'($urandom_range(0, 3));
    for (int i = 0; i < 26000; i++) begin
      applyStimulus(1'b1, 1'b1, (i < 13000) ? 1 : other);
    end

    // Short enable drops restart the raster with a freshly chosen pattern.
    for (int r = 0; r < 8; r++) begin
      sel   = (r < 4) ? r : int'($urandom_range(0, 3));
      other = int'($urandom_range(0, 3));
      drops = int'($urandom_range(1, 3));
      len   = int'($urandom_range(500, 2500));
      mid   = int'($urandom_range(100, 499));
      for (int i = 0; i < drops; i++) applyStimulus(1'b1, 1'b0, sel);
      for (int i = 0; i < len; i++) applyStimulus(1'b1, 1'b1, (i < mid) ? sel : other);
    end

    // Asynchronous reset while hsync is in its asserted level.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      if (eHs == HP) found = 1'b1;
      else applyStimulus(1'b1, 1'b1, 3);
    end
    checkOutput("hsync pulse reached", 32'(found), 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b1, 3);
    for (int i = 0; i < 1500; i++) applyStimulus(1'b1, 1'b1, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
